// File: rtl/wormhole_output_allocator.sv
// Per-output wormhole allocator: a round-robin grant per output, held until the
// owning input sends its TAIL flit. All outputs are driven straight from flops.
module wormhole_output_allocator #(
  parameter int unsigned PORTS       = 4,
  parameter bit          ALLOW_UTURN = 1'b0,
  localparam int unsigned DIR_W      = (PORTS > 2) ? $clog2(PORTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS-1:0]       req_i,
  input  logic [PORTS*DIR_W-1:0] req_dst_i,
  input  logic [PORTS-1:0]       flit_fire_i,
  input  logic [PORTS-1:0]       flit_tail_i,
  output logic [PORTS-1:0]       grant_o,
  output logic [PORTS*DIR_W-1:0] in_route_o,
  output logic [PORTS-1:0]       out_busy_o,
  output logic [PORTS*DIR_W-1:0] sel_o,
  output logic                   err_o
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e           r_state [PORTS];
  logic [DIR_W-1:0] r_owner [PORTS];
  logic [DIR_W-1:0] r_ptr   [PORTS];

  state_e           w_state_nxt [PORTS];
  logic [DIR_W-1:0] w_owner_nxt [PORTS];
  logic [DIR_W-1:0] w_ptr_nxt   [PORTS];
  logic [DIR_W-1:0] w_dst       [PORTS];
  logic [PORTS-1:0] w_cand      [PORTS];
  logic [PORTS-1:0] w_bad_req;
  logic             w_err_evt;

  logic [PORTS-1:0]       w_grant_nxt;
  logic [PORTS-1:0]       w_busy_nxt;
  logic [PORTS*DIR_W-1:0] w_route_nxt;
  logic [PORTS*DIR_W-1:0] w_sel_nxt;

  logic             w_found;
  logic [DIR_W-1:0] w_win;
  logic [DIR_W-1:0] w_scan;
  int unsigned      w_idx;

  // Request decode: illegal requests raise the error and never become candidates
  always_comb begin
    w_err_evt = 1'b0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      w_dst[i]     = req_dst_i[i*DIR_W +: DIR_W];
      w_bad_req[i] = req_i[i] && ((32'(w_dst[i]) >= PORTS) ||
                                  (!ALLOW_UTURN && (32'(w_dst[i]) == i)));
      if (w_bad_req[i] || (flit_fire_i[i] && flit_tail_i[i] && !grant_o[i])) begin
        w_err_evt = 1'b1;
      end
    end
    for (int unsigned o = 0; o < PORTS; o++) begin
      for (int unsigned i = 0; i < PORTS; i++) begin
        w_cand[o][i] = req_i[i] && !w_bad_req[i] && !grant_o[i] && (32'(w_dst[i]) == o);
      end
    end
  end

  // Per-output IDLE/LOCKED next state, round-robin winner and next output image
  always_comb begin
    w_grant_nxt = '0;
    w_busy_nxt  = '0;
    w_route_nxt = '0;
    w_sel_nxt   = '0;
    w_found     = 1'b0;
    w_win       = '0;
    w_scan      = '0;
    w_idx       = 0;
    for (int unsigned o = 0; o < PORTS; o++) begin
      w_state_nxt[o] = r_state[o];
      w_owner_nxt[o] = r_owner[o];
      w_ptr_nxt[o]   = r_ptr[o];
      w_found        = 1'b0;
      w_win          = '0;
      if (r_state[o] == ST_IDLE) begin
        for (int unsigned k = 0; k < PORTS; k++) begin
          w_idx = 32'(r_ptr[o]) + k;
          if (w_idx >= PORTS) begin
            w_idx = w_idx - PORTS;
          end
          w_scan = DIR_W'(w_idx);
          if (!w_found && w_cand[o][w_scan]) begin
            w_found = 1'b1;
            w_win   = w_scan;
          end
        end
        if (w_found) begin
          w_state_nxt[o] = ST_LOCKED;
          w_owner_nxt[o] = w_win;
          w_ptr_nxt[o]   = ((32'(w_win) + 1) >= PORTS) ? '0 : DIR_W'(32'(w_win) + 1);
        end
      end else if (flit_fire_i[r_owner[o]] && flit_tail_i[r_owner[o]]) begin
        w_state_nxt[o] = ST_IDLE;
      end

      if (w_state_nxt[o] == ST_LOCKED) begin
        w_busy_nxt[o]                = 1'b1;
        w_sel_nxt[o*DIR_W +: DIR_W]  = w_owner_nxt[o];
        for (int unsigned i = 0; i < PORTS; i++) begin
          if (w_owner_nxt[o] == DIR_W'(i)) begin
            w_grant_nxt[i]                = 1'b1;
            w_route_nxt[i*DIR_W +: DIR_W] = DIR_W'(o);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned o = 0; o < PORTS; o++) begin
        r_state[o] <= ST_IDLE;
        r_owner[o] <= '0;
        r_ptr[o]   <= '0;
      end
      grant_o    <= '0;
      in_route_o <= '0;
      out_busy_o <= '0;
      sel_o      <= '0;
      err_o      <= 1'b0;
    end else begin
      for (int unsigned o = 0; o < PORTS; o++) begin
        r_state[o] <= w_state_nxt[o];
        r_owner[o] <= w_owner_nxt[o];
        r_ptr[o]   <= w_ptr_nxt[o];
      end
      grant_o    <= w_grant_nxt;
      in_route_o <= w_route_nxt;
      out_busy_o <= w_busy_nxt;
      sel_o      <= w_sel_nxt;
      err_o      <= err_o | w_err_evt;
    end
  end

endmodule

// File: doc/wormhole_output_allocator.md
Name: wormhole_output_allocator

Overview:
Per-output wormhole switch allocator for the mesh router. It is driven by per-input routing requests, after route computation, and by flit-transfer events. It grants each output port to one input using round-robin priority, and holds that connection until the owning input transfers a TAIL flit. Its outputs drive the crossbar select lines and the per-input "route established" status. Port index i equals e_dir value i (NORTH=0, ...).

Parameters:
PORTS, 4, number of router ports (inputs = outputs); legal range 2..8.
DIR_W, max(1,$clog2(PORTS)), localparam; width of one port index.
ALLOW_UTURN, 0, 1 = an input may be routed to its own output index.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
req_i  input  PORTS  input i presents a routed HEADER and wants a connection
req_dst_i  input  PORTS*DIR_W  requested output of input i, slice [i*DIR_W +: DIR_W]
flit_fire_i  input  PORTS  a flit left input i this cycle (enable & downstream ack)
flit_tail_i  input  PORTS  the flit leaving input i is TAIL; qualified by flit_fire_i
grant_o  output  PORTS  input i owns an output (level, registered)
in_route_o  output  PORTS*DIR_W  output owned by input i; valid when grant_o[i]
out_busy_o  output  PORTS  output o is locked
sel_o  output  PORTS*DIR_W  input driving output o; valid when out_busy_o[o]
err_o  output  1  sticky protocol error flag

Behaviour:
- Reset (async, immediate): every output is in IDLE; every priority pointer ptr[o]=0; grant_o, in_route_o, out_busy_o, sel_o and err_o are all 0. A reset during a lock drops the lock with no tail required.
- Per-output FSM, states IDLE and LOCKED, with owner[o] held in a register.
- Candidate input i for output o: req_i[i]=1, req_dst_i[i]==o, req_dst_i[i]<PORTS, grant_o[i]=0, and (ALLOW_UTURN or i!=o).
- IDLE: if any candidate exists, the winner is the first candidate scanning i = ptr[o], ptr[o]+1, ... modulo PORTS. At the next edge the FSM moves to LOCKED, owner<=winner, ptr[o]<=(winner+1) mod PORTS.
- Latency: request seen in cycle N gives grant_o/out_busy_o/sel_o high in cycle N+1.
- LOCKED: if flit_fire_i[owner] and flit_tail_i[owner] are both 1, the FSM returns to IDLE at the next edge, and grant_o[owner] and out_busy_o[o] fall in that cycle.
- No same-cycle handover: an output freed at edge E can be granted only at edge E+1 at the earliest. Minimum gap is one idle cycle.
- Different outputs allocate independently in the same cycle. Each input requests one destination, so one input never wins two outputs.
- Requests from an already-granted input are ignored. Fire/tail events from a non-granted input are ignored.
- err_o is set and held until reset on any of the following:
  - req_dst_i >= PORTS with req_i=1;
  - a U-turn request when ALLOW_UTURN=0;
  - flit_tail_i=1 with flit_fire_i=1 on a non-granted input.
  The offending request is never granted.
- req_i may drop before a grant; the request is simply not considered. Under round-robin, a held request is served within PORTS-1 packets.
- Invariants for assertions:
  - out_busy_o[o] implies grant_o[sel_o[o]] and in_route_o[sel_o[o]]==o.
  - No two busy outputs share one sel value.
- All outputs are registered; there is no combinational path from input to output.

Test Plan:
1. Input 1 requests dst 3 in cycle 0 → cycle 1: grant_o=0010, out_busy_o[3]=1, sel slice 3=1, in_route slice 1=3. Tail fired in cycle 5 → cycle 6: grant_o=0, out_busy_o=0.
2. Contention with ptr[1]=0: inputs 0 and 2 both request dst 1 in cycle 0 → input 0 granted in cycle 1. Input 0 tail in cycle 4 → cycle 5 idle, input 2 granted in cycle 6.
3. Fairness: inputs 0, 1 and 2 hold requests for dst 3; each packet is header plus tail, one cycle apart → grant order 0,1,2,0,1,2 with ptr[3] sequence 1,2,3,1. No input is skipped.
4. Parallel: 0→2 and 1→3 requested in the same cycle → both granted in the next cycle; out_busy_o=1100, err_o=0.
5. Errors with ALLOW_UTURN=0: input 2 requests dst 2 → never granted, err_o=1 from the next cycle on. Then a tail fire on non-granted input 0 → err_o stays 1, no state change.
6. Reset mid-packet: 0→1 locked, rst pulsed → all outputs 0 immediately. After release, input 3 requesting dst 1 is granted one cycle later with ptr[1] having restarted at 0.
